// File: rtl/bitcnt_arbiter.sv
// Round-robin arbiter sharing one registered CLZ/CTZ/POPCNT unit among NREQ
// valid/ready requesters; one operation in flight, response held until accepted.
module bitcnt_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*64-1:0] req_data,
  input  logic [NREQ*3-1:0] req_func,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  op_id;
  logic [63:0]     op_data;
  logic [2:0]      op_func;

  logic [63:0]     data_arr [NREQ];
  logic [2:0]      func_arr [NREQ];
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  rr_next;
  logic            grant_found;
  logic [IDW:0]    cand_sum;
  logic [IDW-1:0]  cand;

  logic [63:0]     unit_in;
  logic [6:0]      clz_cnt;
  logic [6:0]      ctz_cnt;
  logic [6:0]      pop_cnt;
  logic            ctz_found;
  logic [6:0]      cnt;
  logic            func_err;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*64 +: 64];
      func_arr[i] = req_func[i*3 +: 3];
    end
  end

  // Search starts at rr_ptr and wraps modulo NREQ without a power-of-two mask.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand_sum >= (IDW+1)'(NREQ))
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      cand = cand_sum[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign rr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (resetn && state == IDLE && grant_found)
      req_ready[grant] = 1'b1;
  end

  // 32-bit forms pad the low word with ones/zeros so a single 64-bit scan
  // yields the 32-bit result, including the zero-word cases (32).
  always_comb begin
    case (op_func)
      3'b001:  unit_in = {op_data[31:0], 32'hFFFF_FFFF};
      3'b011:  unit_in = {32'hFFFF_FFFF, op_data[31:0]};
      3'b101:  unit_in = {32'h0, op_data[31:0]};
      default: unit_in = op_data;
    endcase
    clz_cnt   = 7'd64;
    ctz_cnt   = 7'd64;
    pop_cnt   = '0;
    ctz_found = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (unit_in[i])
        clz_cnt = 7'd63 - 7'(i);
      if (!ctz_found && unit_in[i]) begin
        ctz_cnt   = 7'(i);
        ctz_found = 1'b1;
      end
      pop_cnt = pop_cnt + 7'(unit_in[i]);
    end
    case (op_func[2:1])
      2'b00:   cnt = clz_cnt;
      2'b01:   cnt = ctz_cnt;
      2'b10:   cnt = pop_cnt;
      default: cnt = '0;
    endcase
  end

  assign func_err = &op_func[2:1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_data   <= '0;
      op_func   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_data <= data_arr[grant];
            op_func <= func_arr[grant];
            op_id   <= grant;
            rr_ptr  <= rr_next;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_err          <= func_err;
          rsp_data         <= func_err ? '0 : {57'b0, cnt};
          rsp_valid        <= '0;
          rsp_valid[op_id] <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (rsp_ready[op_id]) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rsp_onehot: assert property (@(posedge clk) $onehot0(rsp_valid));

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Bench for bitcnt_arbiter: transaction-level model checked every cycle plus
// directed operations with hand-computed results.
module tb_bitcnt_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ*3-1:0] req_func;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [63:0]       rsp_data;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  bitcnt_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_func(req_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_bitcnt(input logic [2:0] f, input logic [63:0] d);
    int w;
    int n;
    w = f[0] ? 32 : 64;
    n = 0;
    case (f[2:1])
      2'b00:   while (n < w && d[w-1-n] == 1'b0) n++;
      2'b01:   while (n < w && d[n] == 1'b0) n++;
      2'b10:   n = f[0] ? $countones(d[31:0]) : $countones(d);
      default: n = 0;
    endcase
    return 64'(n);
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: phase 0 waiting for a grant, 1 computing, 2 response offered.
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  logic [63:0] m_data  = '0;
  logic        m_err   = 1'b0;
  logic [63:0] p_data  = '0;
  logic        p_err   = 1'b0;

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  always @(negedge resetn) begin
    m_phase = 0;
    m_ptr   = 0;
    m_data  = '0;
    m_err   = 1'b0;
  end

  always @(posedge clk) begin : model
    int g;
    logic [2:0] f;
    if (resetn) begin
      case (m_phase)
        0: begin
          g = model_grant();
          if (g >= 0) begin
            m_owner = g;
            m_ptr   = (g + 1) % NREQ;
            f       = req_func[3*g +: 3];
            p_err   = f[2] & f[1];
            p_data  = p_err ? 64'd0 : ref_bitcnt(f, req_data[64*g +: 64]);
            m_phase = 1;
          end
        end
        1: begin
          m_data  = p_data;
          m_err   = p_err;
          m_phase = 2;
        end
        default: begin
          if (rsp_ready[m_owner]) begin
            m_err   = 1'b0;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_rr;
    logic [NREQ-1:0] exp_rv;
    int g;
    #2;
    exp_rr = '0;
    exp_rv = '0;
    if (resetn && m_phase == 0) begin
      g = model_grant();
      if (g >= 0) exp_rr[g] = 1'b1;
    end
    if (m_phase == 2) exp_rv[m_owner] = 1'b1;
    check("cyc_req_ready", req_ready, exp_rr);
    check("cyc_rsp_valid", rsp_valid, exp_rv);
    check("cyc_rsp_data", rsp_data, m_data);
    check("cyc_rsp_err", rsp_err, m_err);
  end

  task automatic wait_grant(input int id, output bit hs);
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      #1;
      if (req_ready[id]) hs = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic do_op(input int id, input logic [2:0] f, input logic [63:0] d,
                       input logic [63:0] exp_d, input logic exp_e, input string name);
    logic [NREQ-1:0] oh;
    bit hs;
    oh = '0;
    oh[id] = 1'b1;
    @(negedge clk);
    req_valid = oh;
    req_func[3*id +: 3] = f;
    req_data[64*id +: 64] = d;
    rsp_ready = '1;
    wait_grant(id, hs);
    check({name, "_handshake"}, 64'(hs), 64'd1);
    @(negedge clk);
    req_valid = '0;
    req_data[64*id +: 64] = ~d;
    req_func[3*id +: 3] = 3'b110;
    #1 check({name, "_exec_valid"}, rsp_valid, 64'd0);
    @(negedge clk);
    #1;
    check({name, "_valid"}, rsp_valid, oh);
    check({name, "_data"}, rsp_data, exp_d);
    check({name, "_err"}, rsp_err, exp_e);
    @(negedge clk);
    #1 check({name, "_done"}, rsp_valid, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish by 100000");
    $fatal(1);
  end

  initial begin
    int g_id [6];
    int g_cyc [6];
    int ng;
    bit hs;
    req_valid = '0;
    req_data  = '0;
    req_func  = '0;
    rsp_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    check("reset_rsp_err", rsp_err, 64'd0);
    check("reset_req_ready", req_ready, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op(0, 3'b000, 64'h1, 64'd63, 1'b0, "clz64_one");
    do_op(2, 3'b011, 64'hFFFF_FFFF_8000_0000, 64'd31, 1'b0, "ctz32");
    do_op(2, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0, "popcnt64");
    do_op(1, 3'b000, 64'h0, 64'd64, 1'b0, "clz64_zero");
    do_op(0, 3'b001, 64'hFFFF_FFFF_0000_0000, 64'd32, 1'b0, "clz32_zero");
    do_op(3, 3'b111, 64'h55, 64'd0, 1'b1, "bad_func");
    do_op(1, 3'b101, 64'hFFFF_0000_0000_00F0, 64'd4, 1'b0, "after_bad");

    // Round-robin from a fresh reset with every requester valid.
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_data[64*i +: 64] = 64'h1 << (8*i);
      req_func[3*i +: 3]   = 3'b010;
    end
    req_valid = '1;
    rsp_ready = '1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (|req_ready) begin
        g_id[ng]  = oh_idx(req_ready);
        g_cyc[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    check("rr_grant_count", 64'(ng), 64'd6);
    check("rr_grant0", 64'(g_id[0]), 64'd0);
    check("rr_grant1", 64'(g_id[1]), 64'd1);
    check("rr_grant2", 64'(g_id[2]), 64'd2);
    check("rr_grant3", 64'(g_id[3]), 64'd3);
    check("rr_grant4", 64'(g_id[4]), 64'd0);
    for (int k = 1; k < 5; k++)
      check("rr_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'd3);
    req_valid = 4'b1001;
    wait_grant(3, hs);
    check("rr_ptr2_pick", req_ready, 64'b1000);
    @(negedge clk) req_valid = '0;
    repeat (3) @(negedge clk);

    // Backpressure on requester 1 while requester 0's ready is high.
    req_valid = 4'b0010;
    req_data[64 +: 64] = 64'h0F00;
    req_func[3 +: 3]   = 3'b010;
    rsp_ready = 4'b0001;
    wait_grant(1, hs);
    check("bp_handshake", 64'(hs), 64'd1);
    @(negedge clk);
    req_valid = 4'b1001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid_hold", rsp_valid, 64'b0010);
      check("bp_data_hold", rsp_data, 64'd8);
      check("bp_no_ready", req_ready, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 4'b0011;
    #1 check("bp_valid_before_accept", rsp_valid, 64'b0010);
    @(negedge clk);
    #1;
    check("bp_released", rsp_valid, 64'd0);
    check("bp_next_grant", req_ready, 64'b1000);
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) @(negedge clk);

    // Reset while an operation is executing.
    req_valid = 4'b0001;
    req_data[0 +: 64] = 64'h10;
    req_func[0 +: 3]  = 3'b000;
    wait_grant(0, hs);
    check("rst_handshake", 64'(hs), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1 resetn = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("rst_no_ghost_rsp", rsp_valid, 64'd0);
      @(negedge clk);
    end
    req_valid = '1;
    #1 check("rst_ptr_zero", req_ready, 64'b0001);
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
